// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Desc     : Fetch, load/store and memory-side signal bundle for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_abort;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_abort,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_rdata, if_ready, ls_rdata, ls_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, if_abort,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_rdata, if_ready, ls_rdata, ls_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Desc     : Single-port memory arbiter for fetch and load/store requesters,
//            with a fetch starvation guard and abortable fetches.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] c_MEM_LAT    = 3'(MEM_LAT);
    localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

    logic [1:0]        r_state,     w_state;
    logic              r_owner_ls,  w_owner_ls;
    logic              r_ls_we,     w_ls_we;
    logic              r_aborted,   w_aborted;
    logic [2:0]        r_wait_cnt,  w_wait_cnt;
    logic [2:0]        r_starve,    w_starve;
    logic              r_mem_en,    w_mem_en;
    logic              r_mem_we,    w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata,  w_ls_rdata;
    logic              r_if_ready,  w_if_ready;
    logic              r_ls_ready,  w_ls_ready;
    logic              r_busy,      w_busy;

    logic w_if_valid;
    logic w_ls_valid;
    logic w_grant_if;

    assign w_if_valid = bus.if_req & ~bus.if_abort;
    assign w_ls_valid = bus.ls_req;
    // Fetch only beats a competing load/store once it has lost STARVE_MAX times in a row
    assign w_grant_if = w_if_valid & (~w_ls_valid | (r_starve == c_STARVE_MAX));

    always_comb begin
        w_state     = r_state;
        w_owner_ls  = r_owner_ls;
        w_ls_we     = r_ls_we;
        w_aborted   = r_aborted;
        w_wait_cnt  = r_wait_cnt;
        w_starve    = r_starve;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_if_rdata  = r_if_rdata;
        w_ls_rdata  = r_ls_rdata;
        w_if_ready  = 1'b0;
        w_ls_ready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_aborted = 1'b0;
                if (w_grant_if) begin
                    w_state     = S_ISSUE;
                    w_owner_ls  = 1'b0;
                    w_ls_we     = 1'b0;
                    w_mem_en    = 1'b1;
                    w_mem_addr  = bus.if_addr;
                    w_mem_wdata = '0;
                    w_starve    = 3'd0;
                end else if (w_ls_valid) begin
                    w_state     = S_ISSUE;
                    w_owner_ls  = 1'b1;
                    w_ls_we     = bus.ls_we;
                    w_mem_en    = 1'b1;
                    w_mem_we    = bus.ls_we;
                    w_mem_addr  = bus.ls_addr;
                    w_mem_wdata = bus.ls_wdata;
                    if (w_if_valid && (r_starve < c_STARVE_MAX)) begin
                        w_starve = r_starve + 3'd1;
                    end
                end
            end

            S_ISSUE: begin
                w_state    = S_WAIT;
                w_wait_cnt = c_MEM_LAT;
                if (!r_owner_ls && bus.if_abort) begin
                    w_aborted = 1'b1;
                end
            end

            S_WAIT: begin
                if (!r_owner_ls && bus.if_abort) begin
                    w_aborted = 1'b1;
                end
                if (r_wait_cnt == 3'd1) begin
                    w_state    = S_RESP;
                    w_wait_cnt = 3'd0;
                    if (r_owner_ls) begin
                        w_ls_ready = 1'b1;
                        if (!r_ls_we) begin
                            w_ls_rdata = bus.mem_rdata;
                        end
                    end else if (!(r_aborted || bus.if_abort)) begin
                        // A flush seen at any point of the fetch drops its result
                        w_if_ready = 1'b1;
                        w_if_rdata = bus.mem_rdata;
                    end
                end else begin
                    w_wait_cnt = r_wait_cnt - 3'd1;
                end
            end

            S_RESP: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner_ls  <= 1'b0;
            r_ls_we     <= 1'b0;
            r_aborted   <= 1'b0;
            r_wait_cnt  <= 3'd0;
            r_starve    <= 3'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_ls_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_owner_ls  <= w_owner_ls;
            r_ls_we     <= w_ls_we;
            r_aborted   <= w_aborted;
            r_wait_cnt  <= w_wait_cnt;
            r_starve    <= w_starve;
            r_mem_en    <= w_mem_en;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_if_rdata  <= w_if_rdata;
            r_ls_rdata  <= w_ls_rdata;
            r_if_ready  <= w_if_ready;
            r_ls_ready  <= w_ls_ready;
            r_busy      <= w_busy;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.ls_ready  = r_ls_ready;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Desc     : Scoreboard bench for mem_arbiter (MEM_LAT=1 instance plus a
//            MEM_LAT=3 instance for mid-transaction reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int LAT1 = 1;
    localparam int LAT2 = 3;

    typedef struct packed {
        int         cyc;
        logic       kind;   // 0 = fetch, 1 = load/store
        logic [7:0] addr;
        logic [7:0] data;
        logic       we;
    } exp_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n2_ready = 0;

    exp_t q_mem[$];
    exp_t q_rsp[$];

    logic [7:0] mem1 [256];
    logic       r1v;
    logic [7:0] r1a;
    logic [2:0] p2v;
    logic [7:0] p2a [3];

    mem_arbiter_if #(.DATA_W(8), .ADDR_W(8)) b1 ();
    mem_arbiter_if #(.DATA_W(8), .ADDR_W(8)) b2 ();

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(LAT1), .STARVE_MAX(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(LAT2), .STARVE_MAX(2)) u_dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (b2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory for instance 1: contents i+0x30, 0x10 holds 0x5A, one-cycle read latency
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 8'(i + 'h30);
            mem1[8'h10] <= 8'h5A;
            r1v <= 1'b0;
            r1a <= 8'h00;
        end else begin
            r1v <= b1.mem_en & ~b1.mem_we;
            r1a <= b1.mem_addr;
            if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
        end
    end
    assign b1.mem_rdata = r1v ? mem1[r1a] : 8'hEE;

    // Memory for instance 2: returns addr+0x30 exactly three cycles after mem_en
    always @(posedge clk) begin
        p2v    <= {p2v[1:0], b2.mem_en};
        p2a[0] <= b2.mem_addr;
        p2a[1] <= p2a[0];
        p2a[2] <= p2a[1];
    end
    assign b2.mem_rdata = p2v[2] ? 8'(p2a[2] + 8'h30) : 8'hEE;

    always @(negedge clk) begin
        if (b2.ls_ready || b2.if_ready) n2_ready <= n2_ready + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic k, input logic [7:0] a,
                                input logic [7:0] d, input logic w);
        exp_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.we = w;
        return e;
    endfunction

    // Scoreboard monitor for instance 1
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (b1.mem_en) begin
                if (q_mem.size() == 0) begin
                    chk("unexpected_mem_en", 32'(b1.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = q_mem.pop_front();
                    chk("mem_en_cycle", 32'(cyc), 32'(e.cyc));
                    chk("mem_addr", 32'(b1.mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(b1.mem_we), 32'(e.we));
                    if (e.we) chk("mem_wdata", 32'(b1.mem_wdata), 32'(e.data));
                end
            end
            if (b1.if_ready && b1.ls_ready) begin
                chk("both_ready", 32'd1, 32'd0);
            end else if (b1.if_ready || b1.ls_ready) begin
                if (q_rsp.size() == 0) begin
                    chk("unexpected_ready", {30'd0, b1.ls_ready, b1.if_ready}, 32'd0);
                end else begin
                    e = q_rsp.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ready_owner", 32'(b1.ls_ready), 32'(e.kind));
                    chk("rdata", 32'(b1.ls_ready ? b1.ls_rdata : b1.if_rdata), 32'(e.data));
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic ls_txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_d);
        b1.ls_req = 1'b1; b1.ls_we = we; b1.ls_addr = a; b1.ls_wdata = wd;
        q_mem.push_back(mk(cyc + 1, 1'b1, a, wd, we));
        q_rsp.push_back(mk(cyc + LAT1 + 2, 1'b1, a, exp_d, we));
        tick(LAT1 + 3);
        b1.ls_req = 1'b0;
    endtask

    task automatic if_txn(input logic [7:0] a, input logic [7:0] exp_d);
        b1.if_req = 1'b1; b1.if_addr = a;
        q_mem.push_back(mk(cyc + 1, 1'b0, a, 8'h00, 1'b0));
        q_rsp.push_back(mk(cyc + LAT1 + 2, 1'b0, a, exp_d, 1'b0));
        tick(LAT1 + 3);
        b1.if_req = 1'b0;
    endtask

    initial begin
        b1.if_req = 0; b1.if_addr = 0; b1.if_abort = 0;
        b1.ls_req = 0; b1.ls_we = 0; b1.ls_addr = 0; b1.ls_wdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.if_abort = 0;
        b2.ls_req = 0; b2.ls_we = 0; b2.ls_addr = 0; b2.ls_wdata = 0;

        tick(2);
        chk("rst_mem_en", 32'(b1.mem_en), 32'd0);
        chk("rst_mem_we", 32'(b1.mem_we), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_ready", {30'd0, b1.if_ready, b1.ls_ready}, 32'd0);
        chk("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
        chk("rst_if_rdata", 32'(b1.if_rdata), 32'd0);
        chk("rst_ls_rdata", 32'(b1.ls_rdata), 32'd0);
        reset = 1'b0; reset2 = 1'b0;
        tick(1);

        // Load, store (rdata unchanged), then load back the stored byte
        ls_txn(1'b0, 8'h10, 8'h00, 8'h5A);
        ls_txn(1'b1, 8'h20, 8'hC3, 8'h5A);
        ls_txn(1'b0, 8'h20, 8'h00, 8'hC3);
        tick(2);

        // Contention: LS, LS, IF repeating
        b1.if_req = 1'b1; b1.if_addr = 8'h50;
        b1.ls_req = 1'b1; b1.ls_we = 1'b0; b1.ls_addr = 8'h60;
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) begin
                q_mem.push_back(mk(cyc + 4*k + 1, 1'b0, 8'h50, 8'h00, 1'b0));
                q_rsp.push_back(mk(cyc + 4*k + 3, 1'b0, 8'h50, 8'h80, 1'b0));
            end else begin
                q_mem.push_back(mk(cyc + 4*k + 1, 1'b1, 8'h60, 8'h00, 1'b0));
                q_rsp.push_back(mk(cyc + 4*k + 3, 1'b1, 8'h60, 8'h90, 1'b0));
            end
        end
        tick(24);
        b1.if_req = 1'b0; b1.ls_req = 1'b0;
        tick(2);

        // Fetch 0x04 aborted during WAIT: no ready, rdata keeps 0x80
        b1.if_req = 1'b1; b1.if_addr = 8'h04;
        q_mem.push_back(mk(cyc + 1, 1'b0, 8'h04, 8'h00, 1'b0));
        tick(2);
        chk("abort_busy_wait", 32'(b1.busy), 32'd1);
        b1.if_abort = 1'b1; b1.if_req = 1'b0;
        tick(1);
        b1.if_abort = 1'b0;
        chk("abort_busy_resp", 32'(b1.busy), 32'd1);
        tick(1);
        chk("abort_busy_idle", 32'(b1.busy), 32'd0);
        chk("abort_if_rdata", 32'(b1.if_rdata), 32'h80);
        if_txn(8'h08, 8'h38);
        tick(2);

        // Back-to-back fetches: mem_en four cycles apart
        if_txn(8'h00, 8'h30);
        if_txn(8'h01, 8'h31);
        tick(3);
        chk("q_mem_empty", 32'(q_mem.size()), 32'd0);
        chk("q_rsp_empty", 32'(q_rsp.size()), 32'd0);

        // Instance 2 (MEM_LAT=3): reset during WAIT
        b2.ls_req = 1'b1; b2.ls_we = 1'b0; b2.ls_addr = 8'h40;
        tick(3);
        chk("r2_busy_wait", 32'(b2.busy), 32'd1);
        reset2 = 1'b1; b2.ls_req = 1'b0;
        tick(1);
        chk("r2_mem_en", 32'(b2.mem_en), 32'd0);
        chk("r2_busy", 32'(b2.busy), 32'd0);
        chk("r2_ready", {30'd0, b2.if_ready, b2.ls_ready}, 32'd0);
        chk("r2_mem_addr", 32'(b2.mem_addr), 32'd0);
        chk("r2_ls_rdata", 32'(b2.ls_rdata), 32'd0);
        reset2 = 1'b0;
        tick(8);
        chk("r2_no_stale_ready", 32'(n2_ready), 32'd0);
        b2.ls_req = 1'b1; b2.ls_addr = 8'h41;
        tick(4);
        chk("r2_ready_early", 32'(b2.ls_ready), 32'd0);
        tick(1);
        chk("r2_ready_lat5", 32'(b2.ls_ready), 32'd1);
        chk("r2_ls_rdata_new", 32'(b2.ls_rdata), 32'h71);
        tick(1);
        b2.ls_req = 1'b0;
        chk("r2_ready_count", 32'(n2_ready), 32'd1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, 8, data width of the shared memory and both requester ports.
REQ-002 Parameter ADDR_W, 8, address width.
REQ-003 Parameter MEM_LAT, 1, cycles from the mem_en-sampled cycle to valid mem_rdata; legal range 1..7.
REQ-004 Parameter STARVE_MAX, 2, consecutive fetch losses before fetch gets forced priority; legal range 1..7.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 if_req  input  1  fetch request; held with if_addr stable until if_ready or if_abort.
REQ-008 if_addr  input  ADDR_W  fetch address (PC).
REQ-009 if_abort  input  1  branch flush; cancels any pending or in-flight fetch.
REQ-010 if_rdata  output  DATA_W  fetched instruction byte, valid while if_ready=1.
REQ-011 if_ready  output  1  one-cycle fetch completion pulse.
REQ-012 ls_req  input  1  load/store request; held stable with ls_we/ls_addr/ls_wdata until ls_ready.
REQ-013 ls_we  input  1  1 = store, 0 = load.
REQ-014 ls_addr  input  ADDR_W  load/store address.
REQ-015 ls_wdata  input  DATA_W  store data.
REQ-016 ls_rdata  output  DATA_W  load data, valid while ls_ready=1.
REQ-017 ls_ready  output  1  one-cycle load/store completion pulse.
REQ-018 mem_en  output  1  memory access strobe, exactly one cycle per transaction.
REQ-019 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-020 mem_addr  output  ADDR_W  memory address, qualified by mem_en.
REQ-021 mem_wdata  output  DATA_W  memory write data, qualified by mem_en.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-023 busy  output  1  high whenever state is not IDLE.

Function
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-025 IDLE: no valid request -> stay; otherwise latch owner, address, we and wdata, then go to ISSUE.
REQ-026 Fetch is a valid request only if if_req=1 and if_abort=0 in that cycle.
REQ-027 Priority when both requests are valid: load/store wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-028 starve_cnt: increments, saturating at STARVE_MAX, when both are valid and load/store wins; clears to 0 whenever fetch is granted.
REQ-029 ISSUE: mem_en=1 for exactly one cycle with the latched mem_we/mem_addr/mem_wdata; next state WAIT with wait counter = MEM_LAT.
REQ-030 WAIT: decrement counter each cycle; in the cycle the counter equals 1, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
REQ-031 RESP: pulse the owner's ready for one cycle, then go to IDLE.
REQ-032 Latency from request sampled in IDLE to ready pulse is MEM_LAT+2 cycles (3 cycles at MEM_LAT=1); at most one transaction is in flight.
REQ-033 Stores leave ls_rdata unchanged; ls_ready still pulses.
REQ-034 if_abort while a fetch is owned (ISSUE/WAIT/RESP): memory access completes, if_rdata is not updated, if_ready is suppressed, and the FSM returns to IDLE on its normal schedule.
REQ-035 A new request may be sampled in the IDLE cycle immediately after RESP; a requester keeping req high there starts a new transaction.
REQ-036 mem_en, if_ready, ls_ready and busy are never high outside the states listed above; if_ready and ls_ready are never high in the same cycle.

Reset
REQ-037 reset=1 at a clock edge forces, on that edge: state IDLE, mem_en/mem_we/if_ready/ls_ready/busy=0, mem_addr/mem_wdata/if_rdata/ls_rdata=0, starve_cnt=0, wait counter=0.
REQ-038 Reset mid-transaction drops the in-flight access; no ready pulse for it follows the deassertion of reset.

Verification
REQ-039 Load, MEM_LAT=1: ls_req=1, ls_we=0, ls_addr=0x10, memory holds 0x5A -> mem_en high 1 cycle later with addr 0x10; ls_ready=1 and ls_rdata=0x5A 3 cycles after request.
REQ-040 Simultaneous: if_req and ls_req both held continuously, STARVE_MAX=2 -> grant order LS, LS, IF, LS, LS, IF; starve_cnt returns to 0 after each IF grant.
REQ-041 Store: ls_we=1, addr 0x20, wdata 0xC3 -> one mem_en cycle with mem_we=1, addr 0x20, wdata 0xC3; ls_ready pulses; ls_rdata unchanged.
REQ-042 Abort: fetch at addr 0x04 granted, if_abort=1 during WAIT -> no if_ready pulse, if_rdata keeps its old value, busy falls on schedule; next fetch to 0x08 completes normally.
REQ-043 Reset mid-WAIT with MEM_LAT=3 -> the next edge gives all outputs 0 and IDLE; no stale ready afterwards; a fresh request after reset completes in 5 cycles.
REQ-044 Back-to-back: if_req held for PC 0x00 then 0x01 -> second mem_en occurs exactly MEM_LAT+3 cycles after the first.
